// File: rtl/bp_initiator.sv
// bp_initiator: turns register read/write commands into BytePipe byte traffic
// and forwards the responder's reply bytes to the response sink.
// A burst read first writes (len-1) to responder register 0. It then discards
// the reply to that setup write and issues the read.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_cg                          clock-gate enable (0 = all flops hold)
//   i_cmd_* / o_cmd_ready         command request (wr, addr, wrData, len)
//   o_rsp_* / i_rsp_ready         response bytes, o_rsp_last on the final byte
//   o_bp_* / i_bp_ready           BytePipe bytes to the responder
//   i_bp_* / o_bp_ready           BytePipe bytes from the responder
//   o_busy                        FSM not in IDLE
module bp_initiator #(
    parameter bit BURST_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cg,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_wr,
    input  logic [6:0] i_cmd_addr,
    input  logic [7:0] i_cmd_wrData,
    input  logic [7:0] i_cmd_len,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic       o_rsp_last,
    output logic [7:0] o_bp_data,
    output logic       o_bp_valid,
    input  logic       i_bp_ready,
    input  logic [7:0] i_bp_data,
    input  logic       i_bp_valid,
    output logic       o_bp_ready,
    output logic       o_busy
);

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP_CMD,
        SETUP_DATA,
        SETUP_RSP,
        CMD,
        WRDATA,
        RSP
    } state_e;

    state_e        state_q, state_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] remain_q, remain_d;
    logic          burst_c;

    // Captured command is a burst read (len 0 and 1 are both single reads).
    assign burst_c = BURST_EN && !wr_q && (len_q >= LW'(2));
    assign o_busy  = (state_q != IDLE);

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        len_d       = len_q;
        o_cmd_ready = 1'b0;
        o_bp_valid  = 1'b0;
        o_bp_data   = '0;
        o_bp_ready  = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_data  = '0;
        o_rsp_last  = 1'b0;
        case (state_q)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    wr_d    = i_cmd_wr;
                    addr_d  = i_cmd_addr;
                    wdata_d = i_cmd_wrData;
                    len_d   = i_cmd_len;
                    if (BURST_EN && !i_cmd_wr && (i_cmd_len >= LW'(2))) begin
                        state_d = SETUP_CMD;
                    end else begin
                        state_d = CMD;
                    end
                end
            end
            SETUP_CMD: begin
                // Write to responder register 0 (burst length).
                o_bp_valid = 1'b1;
                o_bp_data  = 8'h80;
                if (i_bp_ready) state_d = SETUP_DATA;
            end
            SETUP_DATA: begin
                o_bp_valid = 1'b1;
                o_bp_data  = len_q - LW'(1);
                if (i_bp_ready) state_d = SETUP_RSP;
            end
            SETUP_RSP: begin
                // Swallow the setup write's reply byte.
                o_bp_ready = 1'b1;
                if (i_bp_valid) state_d = CMD;
            end
            CMD: begin
                o_bp_valid = 1'b1;
                o_bp_data  = {wr_q, addr_q};
                if (i_bp_ready) begin
                    if (wr_q) begin
                        state_d = WRDATA;
                    end else begin
                        state_d  = RSP;
                        remain_d = burst_c ? len_q : LW'(1);
                    end
                end
            end
            WRDATA: begin
                o_bp_valid = 1'b1;
                o_bp_data  = wdata_q;
                if (i_bp_ready) begin
                    state_d  = RSP;
                    remain_d = LW'(1);
                end
            end
            RSP: begin
                // Zero-latency pass-through between responder and sink.
                o_rsp_data  = i_bp_data;
                o_rsp_valid = i_bp_valid;
                o_bp_ready  = i_rsp_ready;
                o_rsp_last  = (remain_q == LW'(1)) && i_bp_valid;
                if (i_bp_valid && i_rsp_ready) begin
                    remain_d = remain_q - LW'(1);
                    if (remain_q == LW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and down-counter; reset wins over the clock gate.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            remain_q <= '0;
        end else if (i_cg) begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Captured command fields, no reset needed.
    always_ff @(posedge i_clk) begin
        if (i_cg) begin
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
        end
    end

endmodule
